// File: rtl/addsub_serial_if.sv
// addsub_serial_if
//   Groups the request and result handshakes of addsub_serial.
//   master : the requester. It drives in_valid/mode/a/b/out_ready and observes
//            in_ready and the result fields.
//   slave  : the arithmetic unit. It drives in_ready/out_valid/sum/cout/ovf/zero.
// Signals
//   in_valid, in_ready  request handshake (mode, a and b are sampled on accept)
//   out_valid, out_ready result handshake (sum, cout, ovf and zero are valid with out_valid)
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
//   carried out CHUNK bits per clock through one CHUNK-bit ripple slice, with
//   the carry registered between slices. The result is ready NCH = WIDTH/CHUNK
//   cycles after the request is accepted.
// Ports
//   clk  clock; all state changes on the rising edge
//   rst  asynchronous, active-high reset; returns to IDLE and clears the result
//   bus  addsub_serial_if.slave: request (in_valid/in_ready, mode, a, b) and
//        result (out_valid/out_ready, sum, cout, ovf, zero)
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;     // B already inverted for subtract
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDXW-1:0]  idx_reg;

  logic             accept;
  logic             last;
  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic [CHUNK:0]   c;         // c[i] = carry into bit i of the slice

  assign accept = (state_reg == IDLE) && bus.in_valid;
  assign last   = (idx_reg == LAST_IDX);
  assign base   = 32'(idx_reg) * 32'(CHUNK);

  assign slice_a = a_reg[base +: CHUNK];
  assign slice_b = b_reg[base +: CHUNK];

  // One CHUNK-bit ripple slice. Its MSB carry-in (c[CHUNK-1]) is kept
  // visible because on the final slice it is the carry into bit WIDTH-1,
  // which is needed for signed overflow.
  assign c[0] = carry_reg;
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
    assign slice_sum[gi] = slice_a[gi] ^ slice_b[gi] ^ c[gi];
    assign c[gi+1]       = (slice_a[gi] & slice_b[gi]) |
                           (c[gi] & (slice_a[gi] ^ slice_b[gi]));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so there is no
  // combinational path from in_valid or out_ready.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_reg)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture on accept, one slice per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      // Subtract as a + ~b + 1: invert B here and seed the carry with mode.
      a_reg     <= bus.a;
      b_reg     <= bus.b ^ {WIDTH{bus.mode}};
      carry_reg <= bus.mode;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      sum_reg[base +: CHUNK] <= slice_sum;
      carry_reg              <= c[CHUNK];
      // Wrap to 0 on the final slice so idx never selects past the operand.
      idx_reg                <= last ? '0 : idx_reg + 1'b1;
      if (last) begin
        cout_reg <= c[CHUNK];
        ovf_reg  <= c[CHUNK] ^ c[CHUNK-1];
      end
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.zero = ~|sum_reg;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial
//   Drives three addsub_serial instances (CHUNK = 4, 16, 1 at WIDTH = 16)
//   through directed vectors, backpressure, a mid-operation reset and random
//   vectors, comparing against an arithmetic reference model.
module tb_addsub_serial;
  localparam int W    = 16;
  localparam int NCFG = 3;
  localparam int CHUNK_TAB [NCFG] = '{4, 16, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_v       [NCFG];
  logic         in_valid_v  [NCFG];
  logic         in_ready_v  [NCFG];
  logic         mode_v      [NCFG];
  logic [W-1:0] a_v         [NCFG];
  logic [W-1:0] b_v         [NCFG];
  logic         out_valid_v [NCFG];
  logic         out_ready_v [NCFG];
  logic [W-1:0] sum_v       [NCFG];
  logic         cout_v      [NCFG];
  logic         ovf_v       [NCFG];
  logic         zero_v      [NCFG];

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    addsub_serial_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid_v[gi];
    assign bus.mode      = mode_v[gi];
    assign bus.a         = a_v[gi];
    assign bus.b         = b_v[gi];
    assign bus.out_ready = out_ready_v[gi];
    assign in_ready_v[gi]  = bus.in_ready;
    assign out_valid_v[gi] = bus.out_valid;
    assign sum_v[gi]       = bus.sum;
    assign cout_v[gi]      = bus.cout;
    assign ovf_v[gi]       = bus.ovf;
    assign zero_v[gi]      = bus.zero;

    addsub_serial #(.WIDTH(W), .CHUNK(CHUNK_TAB[gi])) dut (
      .clk (clk),
      .rst (rst_v[gi]),
      .bus (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {zero, ovf, cout, sum}.
  function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic m);
    int full;
    int exact;
    logic [15:0] s;
    logic c;
    logic o;
    if (m) begin
      full  = int'(a) - int'(b) + 65536;          // bit 16 set <=> no borrow
      exact = int'($signed(a)) - int'($signed(b));
    end else begin
      full  = int'(a) + int'(b);
      exact = int'($signed(a)) + int'($signed(b));
    end
    s = full[15:0];
    c = full[16];
    o = (exact > 32767) || (exact < -32768);
    return {(s == 16'h0000), o, c, s};
  endfunction

  // Directed vectors {mode, a, b} with hand-derived {zero, ovf, cout, sum}.
  logic [32:0] dir_in [6] = '{
    {1'b0, 16'h7FFF, 16'h0001},
    {1'b1, 16'h0005, 16'h0003},
    {1'b1, 16'h8000, 16'h0001},
    {1'b1, 16'h0000, 16'h0001},
    {1'b1, 16'h1234, 16'h1234},
    {1'b0, 16'hFFFF, 16'h0001}
  };
  logic [18:0] dir_exp [6] = '{
    {1'b0, 1'b1, 1'b0, 16'h8000},
    {1'b0, 1'b0, 1'b1, 16'h0002},
    {1'b0, 1'b1, 1'b1, 16'h7FFF},
    {1'b0, 1'b0, 1'b0, 16'hFFFF},
    {1'b1, 1'b0, 1'b1, 16'h0000},
    {1'b1, 1'b0, 1'b1, 16'h0000}
  };

  task automatic check_reset(input int k, input string tag);
    check({tag, ".hs"},    {30'd0, out_valid_v[k], in_ready_v[k]}, 32'd1);
    check({tag, ".sum"},   32'(sum_v[k]), 32'd0);
    check({tag, ".flags"}, {29'd0, zero_v[k], ovf_v[k], cout_v[k]}, 32'd4);
  endtask

  // Called at a negedge with the block idle; returns at the first negedge
  // after the accepting edge, with the operands already scrambled.
  task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input string tag);
    check({tag, ".idle"}, 32'(in_ready_v[k]), 32'd1);
    a_v[k] = a; b_v[k] = b; mode_v[k] = m; in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); mode_v[k] = 1'($urandom);
  endtask

  // Waits (bounded) for out_valid and checks latency and result fields.
  task automatic wait_result(input int k, input logic [18:0] e, input string tag);
    int lat = 0;
    check({tag, ".busy"}, 32'(in_ready_v[k]), 32'd0);
    while (!out_valid_v[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"},  32'(lat), 32'(W / CHUNK_TAB[k]));
    check({tag, ".sum"},  32'(sum_v[k]), 32'(e[15:0]));
    check({tag, ".cout"}, 32'(cout_v[k]), 32'(e[16]));
    check({tag, ".ovf"},  32'(ovf_v[k]),  32'(e[17]));
    check({tag, ".zero"}, 32'(zero_v[k]), 32'(e[18]));
    $display("%s cfg=%0d chunk=%0d lat=%0d sum=%h cout=%b ovf=%b zero=%b", tag, k,
             CHUNK_TAB[k], lat, sum_v[k], cout_v[k], ovf_v[k], zero_v[k]);
  endtask

  task automatic drain(input int k, input string tag);
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    check({tag, ".drain"}, {30'd0, out_valid_v[k], in_ready_v[k]}, 32'd1);
  endtask

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic [18:0] e, input string tag);
    start_op(k, a, b, m, tag);
    wait_result(k, e, tag);
    drain(k, tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    logic [18:0] e;

    for (int k = 0; k < NCFG; k++) begin
      rst_v[k] = 1'b1; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      mode_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NCFG; k++) check_reset(k, $sformatf("rst%0d", k));
    for (int k = 0; k < NCFG; k++) rst_v[k] = 1'b0;
    @(negedge clk);

    // Directed vectors on every configuration.
    for (int k = 0; k < NCFG; k++)
      for (int i = 0; i < 6; i++)
        run_op(k, dir_in[i][31:16], dir_in[i][15:0], dir_in[i][32], dir_exp[i],
               $sformatf("dir%0d", i));

    // Backpressure: result held for 10 cycles while in_valid toggles.
    ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
    e = ref_op(ra, rb, rm);
    start_op(0, ra, rb, rm, "bp");
    wait_result(0, e, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = ~in_valid_v[0];
      a_v[0] = 16'($urandom); b_v[0] = 16'($urandom); mode_v[0] = 1'($urandom);
      @(negedge clk);
      check("bp.hold_sum", 32'(sum_v[0]), 32'(e[15:0]));
      check("bp.hold_flags", {29'd0, zero_v[0], ovf_v[0], cout_v[0]}, 32'(e[18:16]));
      check("bp.hold_hs", {30'd0, out_valid_v[0], in_ready_v[0]}, 32'd2);
    end
    ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
    e = ref_op(ra, rb, rm);
    a_v[0] = ra; b_v[0] = rb; mode_v[0] = rm; in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check("bp.release", {30'd0, out_valid_v[0], in_ready_v[0]}, 32'd1);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    a_v[0] = 16'($urandom); b_v[0] = 16'($urandom); mode_v[0] = 1'($urandom);
    wait_result(0, e, "bp2");
    drain(0, "bp2");

    // Reset in the second RUN cycle, then a clean operation.
    start_op(0, 16'hFFFF, 16'h0001, 1'b0, "mid");
    @(negedge clk);
    rst_v[0] = 1'b1;
    #1;
    check_reset(0, "mid.rst");
    @(negedge clk);
    rst_v[0] = 1'b0;
    @(negedge clk);
    run_op(0, 16'h0F0F, 16'h00F1, 1'b0, ref_op(16'h0F0F, 16'h00F1, 1'b0), "post");

    // Random sweep on every configuration.
    for (int k = 0; k < NCFG; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
        run_op(k, ra, rb, rm, ref_op(ra, rb, rm), $sformatf("rnd%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
